// File: rtl/cnet_reg_master_pkg.sv
// Shared encodings and defaults for the CPCI-side CNET register master.
package cnet_reg_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int DEF_ADDR_WIDTH     = 27;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    // Read result on timeout is this bit replicated across the data width.
    localparam bit TIMEOUT_RD_FILL = 1'b1;

endpackage

// File: rtl/cnet_reg_timer.sv
// REQ-phase watchdog: clear/enable counter with a terminal-count flag at TIMEOUT_CYCLES-1.
module cnet_reg_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] cnt;

    assign tc = (cnt == CW'(TIMEOUT_CYCLES - 1));

    // Holding at terminal count keeps power-of-two sizes from wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !tc)
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/cnet_reg_master.sv
// Issues single host register reads/writes onto the CPCI<->CNET bus and reports completion/timeout.
module cnet_reg_master
    import cnet_reg_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_req,
    input  logic                  host_rd_wr_L,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wr_data,
    output logic                  host_busy,
    output logic                  host_done,
    output logic                  host_timeout,
    output logic [DATA_WIDTH-1:0] host_rd_data,
    output logic                  cpci_req,
    output logic                  cpci_rd_wr_L,
    output logic [ADDR_WIDTH-1:0] cpci_addr,
    inout  wire  [DATA_WIDTH-1:0] cpci_data,
    input  logic                  cpci_wr_rdy,
    input  logic                  cpci_rd_rdy
);

    state_t                state, state_d;
    logic                  req_d, rw_d, oe, oe_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata, wdata_d, rdata_d;
    logic                  busy_d, done_d, to_d;
    logic                  match, tmr_clr, tmr_en, tmr_tc;

    cnet_reg_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .tc    (tmr_tc)
    );

    // Output enable is a flop so reset tristates the bus asynchronously.
    assign cpci_data = oe ? wdata : 'z;

    always_comb begin
        state_d = state;
        req_d   = cpci_req;
        rw_d    = cpci_rd_wr_L;
        addr_d  = cpci_addr;
        wdata_d = wdata;
        oe_d    = oe;
        busy_d  = host_busy;
        done_d  = 1'b0;
        to_d    = host_timeout;
        rdata_d = host_rd_data;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        match   = cpci_rd_wr_L ? cpci_rd_rdy : cpci_wr_rdy;
        case (state)
            ST_IDLE: begin
                if (host_req) begin
                    rw_d    = host_rd_wr_L;
                    addr_d  = host_addr;
                    wdata_d = host_wr_data;
                    oe_d    = !host_rd_wr_L;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                    tmr_clr = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // A matching ready on the terminal-count cycle still completes normally.
                if (match) begin
                    req_d   = 1'b0;
                    oe_d    = 1'b0;
                    done_d  = 1'b1;
                    to_d    = 1'b0;
                    if (cpci_rd_wr_L)
                        rdata_d = cpci_data;
                    state_d = ST_GAP;
                end else if (tmr_tc) begin
                    req_d   = 1'b0;
                    oe_d    = 1'b0;
                    done_d  = 1'b1;
                    to_d    = 1'b1;
                    if (cpci_rd_wr_L)
                        rdata_d = {DATA_WIDTH{TIMEOUT_RD_FILL}};
                    state_d = ST_GAP;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_GAP: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cpci_req     <= 1'b0;
            cpci_rd_wr_L <= 1'b1;
            cpci_addr    <= '0;
            wdata        <= '0;
            oe           <= 1'b0;
            host_busy    <= 1'b0;
            host_done    <= 1'b0;
            host_timeout <= 1'b0;
            host_rd_data <= '0;
        end else begin
            state        <= state_d;
            cpci_req     <= req_d;
            cpci_rd_wr_L <= rw_d;
            cpci_addr    <= addr_d;
            wdata        <= wdata_d;
            oe           <= oe_d;
            host_busy    <= busy_d;
            host_done    <= done_d;
            host_timeout <= to_d;
            host_rd_data <= rdata_d;
        end
    end

endmodule

// File: tb/tb_cnet_reg_master.sv
// Directed bench for cnet_reg_master with an inline CNET responder (TIMEOUT_CYCLES=8).
module tb_cnet_reg_master;

    localparam int AW = 27;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          host_req, host_rd_wr_L;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wr_data;
    logic          host_busy, host_done, host_timeout;
    logic [DW-1:0] host_rd_data;
    logic          cpci_req, cpci_rd_wr_L;
    logic [AW-1:0] cpci_addr;
    wire  [DW-1:0] cpci_data;
    logic          cpci_wr_rdy, cpci_rd_rdy;
    logic          resp_oe;
    logic [DW-1:0] resp_data;
    logic [DW-1:0] last_wdata;

    int checks   = 0;
    int failures = 0;

    assign cpci_data = resp_oe ? resp_data : 'z;

    always #5 clk = ~clk;

    cnet_reg_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .host_req     (host_req),
        .host_rd_wr_L (host_rd_wr_L),
        .host_addr    (host_addr),
        .host_wr_data (host_wr_data),
        .host_busy    (host_busy),
        .host_done    (host_done),
        .host_timeout (host_timeout),
        .host_rd_data (host_rd_data),
        .cpci_req     (cpci_req),
        .cpci_rd_wr_L (cpci_rd_wr_L),
        .cpci_addr    (cpci_addr),
        .cpci_data    (cpci_data),
        .cpci_wr_rdy  (cpci_wr_rdy),
        .cpci_rd_rdy  (cpci_rd_rdy)
    );

    typedef struct {
        bit            rd;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            lat;    // matching ready asserted once more than lat REQ cycles have elapsed
        bit            wrong;  // pulse the other-direction ready on REQ cycle 2
        bit            eto;
        logic [DW-1:0] erd;
        int            ereq;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Caller is at a negedge with host_busy=0; returns at a negedge one cycle after host_done.
    task automatic txn(input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int lat, input bit wrong,
                       output bit done, output bit to, output logic [DW-1:0] rdat,
                       output int reqc, output bit bus_ok, output bit gap_ok);
        done = 0; to = 0; rdat = '0; reqc = 0; bus_ok = 1; gap_ok = 1;
        host_req = 1'b1; host_rd_wr_L = rd; host_addr = a; host_wr_data = d;
        @(negedge clk);
        host_req = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (host_done) begin
                done = 1; to = host_timeout; rdat = host_rd_data;
                if (cpci_req || !host_busy) gap_ok = 0;
                break;
            end
            if (cpci_req) begin
                reqc++;
                if (!rd && cpci_data !== d) bus_ok = 0;
                if (rd && !resp_oe && cpci_data === last_wdata) bus_ok = 0;
                if (cpci_addr !== a || cpci_rd_wr_L !== rd) bus_ok = 0;
                cpci_wr_rdy = !rd && (reqc > lat);
                cpci_rd_rdy = (rd && (reqc > lat)) || (wrong && reqc == 2);
                resp_oe     = rd && (reqc > lat);
                resp_data   = DW'(cpci_addr);
            end else begin
                cpci_wr_rdy = 1'b0; cpci_rd_rdy = 1'b0; resp_oe = 1'b0;
            end
            @(negedge clk);
        end
        cpci_wr_rdy = 1'b0; cpci_rd_rdy = 1'b0; resp_oe = 1'b0;
        @(negedge clk);
        if (cpci_req || host_busy || host_done) gap_ok = 0;
        if (!rd) last_wdata = d;
    endtask

    initial begin
        bit            done, to, bus_ok, gap_ok, saw_done;
        logic [DW-1:0] rdat;
        int            reqc;

        reset = 1'b1; host_req = 1'b0; host_rd_wr_L = 1'b1; host_addr = '0; host_wr_data = '0;
        cpci_wr_rdy = 1'b0; cpci_rd_rdy = 1'b0; resp_oe = 1'b0; resp_data = '0;
        last_wdata = 32'hA5A5_A5A5;

        vt[0] = '{0, 27'h0000123, 32'hCAFEF00D, 1,  0, 0, 32'h0000_0000, 2};
        vt[1] = '{1, 27'h0000ABC, 32'h0,        3,  0, 0, 32'h0000_0ABC, 4};
        vt[2] = '{1, 27'h0000055, 32'h0,        99, 0, 1, 32'hFFFF_FFFF, 8};
        vt[3] = '{0, 27'h00007FF, 32'h1357_9BDF, 6, 1, 0, 32'hFFFF_FFFF, 7};
        vt[4] = '{0, 27'h0000000, 32'h1234_5678, 99, 0, 1, 32'hFFFF_FFFF, 8};
        vt[5] = '{1, 27'h7FFFFFF, 32'h0,        7,  0, 0, 32'h07FF_FFFF, 8};
        vt[6] = '{1, 27'h0000001, 32'h0,        0,  0, 0, 32'h0000_0001, 1};

        repeat (2) @(negedge clk);
        chk("rst_req",   DW'(cpci_req), 0);
        chk("rst_rdwr",  DW'(cpci_rd_wr_L), 1);
        chk("rst_addr",  DW'(cpci_addr), 0);
        chk("rst_busy",  DW'(host_busy), 0);
        chk("rst_done",  DW'(host_done), 0);
        chk("rst_to",    DW'(host_timeout), 0);
        chk("rst_rdata", host_rd_data, 0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vt[i]) begin
            txn(vt[i].rd, vt[i].a, vt[i].d, vt[i].lat, vt[i].wrong, done, to, rdat, reqc, bus_ok, gap_ok);
            chk($sformatf("v%0d_done", i),   DW'(done), 1);
            chk($sformatf("v%0d_to", i),     DW'(to), DW'(vt[i].eto));
            chk($sformatf("v%0d_rdata", i),  rdat, vt[i].erd);
            chk($sformatf("v%0d_reqcyc", i), DW'(reqc), DW'(vt[i].ereq));
            chk($sformatf("v%0d_bus", i),    DW'(bus_ok), 1);
            chk($sformatf("v%0d_gap", i),    DW'(gap_ok), 1);
        end

        // Reset two cycles into a write: bus releases at once, no completion follows.
        host_req = 1'b1; host_rd_wr_L = 1'b0; host_addr = 27'h0000456; host_wr_data = 32'h0BAD_BEEF;
        @(negedge clk);
        host_req = 1'b0;
        @(negedge clk);
        chk("pre_rst_req", DW'(cpci_req), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_req",  DW'(cpci_req), 0);
        chk("mid_rst_busy", DW'(host_busy), 0);
        chk("mid_rst_bus",  DW'(cpci_data === 32'h0BAD_BEEF), 0);
        @(negedge clk);
        reset = 1'b0;
        last_wdata = 32'h0BAD_BEEF;
        saw_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (host_done || cpci_req) saw_done = 1;
        end
        chk("post_rst_quiet", DW'(saw_done), 0);
        txn(1, 27'h0000321, 32'h0, 2, 0, done, to, rdat, reqc, bus_ok, gap_ok);
        chk("post_rst_done",  DW'(done), 1);
        chk("post_rst_to",    DW'(to), 0);
        chk("post_rst_rdata", rdat, 32'h0000_0321);
        chk("post_rst_bus",   DW'(bus_ok), 1);

        // Back-to-back random traffic; responder latency stays below the timeout.
        for (int n = 0; n < 200; n++) begin
            bit            rd;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            rd = 1'($urandom_range(0, 1));
            a  = AW'($urandom);
            d  = $urandom | 32'h1;
            txn(rd, a, d, int'($urandom_range(0, 5)), 0, done, to, rdat, reqc, bus_ok, gap_ok);
            chk($sformatf("r%0d_done", n), DW'(done), 1);
            chk($sformatf("r%0d_to", n),   DW'(to), 0);
            chk($sformatf("r%0d_gap", n),  DW'(gap_ok), 1);
            chk($sformatf("r%0d_bus", n),  DW'(bus_ok), 1);
            if (rd) chk($sformatf("r%0d_rdata", n), rdat, DW'(a));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cnet_reg_master.md
Name: cnet_reg_master

Overview:
CPCI-side initiator for the CPCI↔CNET register interface. It takes single register read/write requests from the CPCI host-access logic and drives cpci_req, cpci_rd_wr_L, cpci_addr and cpci_data toward the CNET. It then waits for the CNET's cpci_wr_rdy or cpci_rd_rdy, captures read data, and returns completion or timeout status to the host side. It sits between the PCI target register decode and the CNET pins, and it is the counterpart of the CNET responder model used in verification.

Parameters:
- ADDR_WIDTH, 27, CNET register address width (matches CPCI_CNET_ADDR_WIDTH).
- DATA_WIDTH, 32, CNET data bus width (matches CPCI_CNET_DATA_WIDTH).
- TIMEOUT_CYCLES, 1024, maximum REQ cycles without a matching ready before abort; valid range ≥2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- host_req  in  1  request strobe; sampled only while host_busy=0.
- host_rd_wr_L  in  1  1=read, 0=write.
- host_addr  in  ADDR_WIDTH  register address.
- host_wr_data  in  DATA_WIDTH  write data.
- host_busy  out  1  high from the cycle after acceptance until return to IDLE.
- host_done  out  1  one-cycle completion pulse.
- host_timeout  out  1  qualifies host_done; 1 = aborted.
- host_rd_data  out  DATA_WIDTH  read result; valid while host_done=1 and held until the next done.
- cpci_req  out  1  request to CNET.
- cpci_rd_wr_L  out  1  direction to CNET.
- cpci_addr  out  ADDR_WIDTH  address to CNET.
- cpci_data  inout  DATA_WIDTH  driven only during a write in REQ; 'z otherwise.
- cpci_wr_rdy  in  1  CNET write acknowledge.
- cpci_rd_rdy  in  1  CNET read acknowledge; cpci_data is valid while this is high.

Behaviour:
- Reset values:
  - State IDLE; cpci_req=0, cpci_rd_wr_L=1, cpci_addr=0.
  - cpci_data='z.
  - host_busy=0, host_done=0, host_timeout=0, host_rd_data=0.
  - Timeout counter = 0.
- Reset mid-transaction: cpci_req drops and the bus tristates immediately (asynchronous). No host_done pulse is generated.
- All outputs are registered. The cpci_data output enable is registered as (state==REQ && !cpci_rd_wr_L).
- States: IDLE, REQ, GAP.
- IDLE:
  - On host_req=1, latch addr, direction and write data into the cpci_* registers.
  - Set cpci_req=1, host_busy=1, clear the counter, go to REQ.
  - Latency: host_req sampled at edge N → cpci_req high after edge N.
- REQ:
  - Matching ready means cpci_rd_rdy for a read, cpci_wr_rdy for a write.
  - On a matching ready at edge M:
    - cpci_req←0, host_done←1, host_timeout←0, go to GAP.
    - For a read, host_rd_data←cpci_data sampled at edge M.
  - A non-matching ready (e.g. rd_rdy during a write) is ignored and the counter continues.
  - No matching ready: the counter increments.
  - When counter==TIMEOUT_CYCLES-1 with no matching ready:
    - cpci_req←0, host_done←1, host_timeout←1, go to GAP.
    - For a read, host_rd_data←all ones; for a write, host_rd_data is unchanged.
  - If a matching ready arrives on the timeout cycle, ready wins (normal completion).
- GAP:
  - One cycle; host_done←0, go to IDLE.
  - host_busy stays high in GAP and falls when IDLE is entered.
  - cpci_req is guaranteed low for at least 2 consecutive cycles between transactions (GAP + IDLE), which lets the CNET re-arm its ready logic.
- host_req while host_busy=1 is ignored. There is no queuing.
- Write data and address stay stable on the bus for the whole REQ state.
- Counter width is clog2(TIMEOUT_CYCLES). It never wraps, because the timeout transition occurs first.

Decomposition:
- Shared defines/package holds:
  - State encodings (IDLE=2'd0, REQ=2'd1, GAP=2'd2).
  - Default widths ADDR_WIDTH=27, DATA_WIDTH=32.
  - TIMEOUT_CYCLES default.
  - Timeout read value (all ones).
- One natural sub-module: cnet_reg_timer, a clear/enable counter with a terminal-count flag at TIMEOUT_CYCLES-1. It uses the same clk and async reset.

Test Plan:
1. Write, immediate ready: host write addr=0x0000123, data=0xCAFEF00D; CNET asserts wr_rdy 1 cycle after req → cpci_data=0xCAFEF00D throughout REQ, host_done 1 cycle later with host_timeout=0, then cpci_req low ≥2 cycles.
2. Read, delayed ready: read addr=0x0000ABC; responder returns addr as data after 3 cycles → host_rd_data=0x00000ABC on the host_done cycle, and cpci_data is never driven by the master.
3. Timeout: TIMEOUT_CYCLES=8, read with no ready → cpci_req high exactly 8 cycles, then host_done=1, host_timeout=1, host_rd_data=0xFFFFFFFF.
4. Wrong-direction ready: during a write, pulse rd_rdy, then assert wr_rdy 5 cycles later → rd_rdy ignored, completion only on wr_rdy, host_timeout=0.
5. Reset mid-REQ: assert reset 2 cycles into a write → cpci_req=0 and cpci_data='z immediately, no host_done, host_busy=0; a new read after reset completes normally.
6. Back-to-back with the random-latency CNET model: 200 random reads/writes issued as soon as host_busy=0 → every read returns its address, no timeouts, and cpci_req is never high across a GAP.
